// File: rtl/jk_excite_driver.sv
// Drives J/K of a WIDTH-bit JK array from its read-back state to a captured target, then verifies.
// Optional macro JK_RETRY_EN: re-excite up to MAX_RETRY times after a failed verify.
module jk_excite_driver #(
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int MAX_RETRY   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             mismatch
);
  localparam int HW = $clog2(HOLD_CYCLES) + 1;

  if (HOLD_CYCLES < 1 || MAX_RETRY < 0) begin : g_param_check
    $error("jk_excite_driver: HOLD_CYCLES must be >= 1 and MAX_RETRY >= 0");
  end

  typedef enum logic [1:0] {IDLE, EXCITE, VERIFY, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] tgt_r, tgt_n, j_n, k_n;
  logic [HW-1:0]    hold_cnt, hold_n;
  logic             busy_n, done_n, mismatch_n;

`ifdef JK_RETRY_EN
  localparam int RW = $clog2(MAX_RETRY + 1) + 1;
  logic [RW-1:0] retry_cnt, retry_n;
`endif

  // Set-only / reset-only drive: correct bits get J=K=0, so J&K is never 1.
  function automatic logic [2*WIDTH-1:0] excite(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] t);
    return {~q & t, q & ~t};
  endfunction

  always_comb begin
    state_n    = state;
    tgt_n      = tgt_r;
    hold_n     = hold_cnt;
    j_n        = '0;
    k_n        = '0;
    busy_n     = busy;
    done_n     = 1'b0;
    mismatch_n = mismatch;
`ifdef JK_RETRY_EN
    retry_n    = retry_cnt;
`endif
    case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (start) begin
          tgt_n      = target;
          hold_n     = '0;
`ifdef JK_RETRY_EN
          retry_n    = '0;
`endif
          {j_n, k_n} = excite(q_fb, target);
          busy_n     = 1'b1;
          state_n    = EXCITE;
        end
      end
      EXCITE: begin
        if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
          state_n = VERIFY;
        end else begin
          hold_n     = hold_cnt + 1'b1;
          {j_n, k_n} = excite(q_fb, tgt_r);
        end
      end
      VERIFY: begin
        if (q_fb == tgt_r) begin
          state_n    = DONE;
          done_n     = 1'b1;
          busy_n     = 1'b0;
          mismatch_n = 1'b0;
        end else begin
`ifdef JK_RETRY_EN
          if (retry_cnt < RW'(MAX_RETRY)) begin
            retry_n    = retry_cnt + 1'b1;
            hold_n     = '0;
            {j_n, k_n} = excite(q_fb, tgt_r);
            state_n    = EXCITE;
          end else begin
            state_n    = DONE;
            done_n     = 1'b1;
            busy_n     = 1'b0;
            mismatch_n = 1'b1;
          end
`else
          state_n    = DONE;
          done_n     = 1'b1;
          busy_n     = 1'b0;
          mismatch_n = 1'b1;
`endif
        end
      end
      DONE: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tgt_r    <= '0;
      hold_cnt <= '0;
      j        <= '0;
      k        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      state    <= state_n;
      tgt_r    <= tgt_n;
      hold_cnt <= hold_n;
      j        <= j_n;
      k        <= k_n;
      busy     <= busy_n;
      done     <= done_n;
      mismatch <= mismatch_n;
    end
  end

`ifdef JK_RETRY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) retry_cnt <= '0;
    else       retry_cnt <= retry_n;
  end
`endif

endmodule
